// File: rtl/ser_pkg.sv
// Shared types and constants for the word serializer.
// Optional macro SERIAL_PARITY_EN adds an even-parity bit to every frame.
package ser_pkg;

   localparam int WORD_W = 16;

`ifdef SERIAL_PARITY_EN
   localparam int FRAME_BITS = 19;
`else
   localparam int FRAME_BITS = 18;
`endif

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } ser_state_e;

endpackage

// File: rtl/ser_fifo.sv
// Word FIFO with synchronous push/pop, full/empty flags and occupancy count.
// Pushes while full and pops while empty are ignored.
module ser_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     push_i,
   input  logic [W-1:0]             wdata_i,
   input  logic                     pop_i,
   output logic [W-1:0]             rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   count_q;
   logic          push_ok;
   logic          pop_ok;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // Pointer and occupancy bookkeeping; simultaneous push and pop leave count unchanged.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + AW'(1);
         if (pop_ok)  rd_q <= rd_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage array; contents are don't-care while the slot is unoccupied.
   always_ff @(posedge CLK) begin
      if (push_ok) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/word_serializer.sv
// Buffers 16-bit words and shifts them out LSB-first as UART-style frames:
// start bit, 16 data bits, optional even parity, stop bit.
// Optional macro SERIAL_PARITY_EN enables the parity bit (PAR state).
module word_serializer
   import ser_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int BAUD_DIV = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [WORD_W-1:0] IN_DATA,
   input  logic              IN_VALID,
   output logic              IN_READY,
   output logic              SER_OUT,
   output logic              SER_FRAME,
   output logic              BUSY,
   output logic [15:0]       WORD_COUNT
);

   localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam int CW = $clog2(DEPTH) + 1;

   ser_state_e        state_q, state_d;
   logic [BW-1:0]     baud_q, baud_d;
   logic [3:0]        bit_q, bit_d;
   logic [WORD_W-1:0] shift_q, shift_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              ser_q, ser_d;
   logic              frame_q, frame_d;
`ifdef SERIAL_PARITY_EN
   logic              par_q, par_d;
`endif

   logic              pop;
   logic              baud_done;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic [WORD_W-1:0] fifo_head;

   ser_fifo #(
      .DEPTH (DEPTH),
      .W     (WORD_W)
   ) u_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .push_i  (IN_VALID),
      .wdata_i (IN_DATA),
      .pop_i   (pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign baud_done  = (baud_q == BAUD_LAST);
   assign IN_READY   = !fifo_full;
   assign BUSY       = (state_q != IDLE) || (fifo_count != '0);
   assign SER_OUT    = ser_q;
   assign SER_FRAME  = frame_q;
   assign WORD_COUNT = cnt_q;

   // State register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic; pops happen from IDLE or at the end of STOP so frames run back to back.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = START;
            end
         end
         START: if (baud_done) state_d = DATA;
         DATA: begin
            if (baud_done && (bit_q == 4'd15)) begin
`ifdef SERIAL_PARITY_EN
               state_d = PAR;
`else
               state_d = STOP;
`endif
            end
         end
`ifdef SERIAL_PARITY_EN
         PAR: if (baud_done) state_d = STOP;
`endif
         STOP: begin
            if (baud_done) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values: baud divider, bit counter, shifter, parity and frame counter.
   always_comb begin
      baud_d  = baud_q + BW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_PARITY_EN
      par_d   = par_q;
`endif
      if ((state_d != state_q) || baud_done || (state_q == IDLE)) baud_d = '0;
      if ((state_q == DATA) && baud_done) begin
         bit_d   = bit_q + 4'd1;
         shift_d = {1'b0, shift_q[WORD_W-1:1]};
      end
      if (pop) begin
         bit_d   = '0;
         shift_d = fifo_head;
`ifdef SERIAL_PARITY_EN
         par_d   = ^fifo_head;
`endif
      end
      if ((state_q == STOP) && baud_done) cnt_d = cnt_q + 16'd1;
   end

   // Output logic driven from the next state so the serial line is a clean register.
   always_comb begin
      ser_d   = 1'b1;
      frame_d = 1'b1;
      case (state_d)
         IDLE:  frame_d = 1'b0;
         START: ser_d   = 1'b0;
         DATA:  ser_d   = shift_d[0];
`ifdef SERIAL_PARITY_EN
         PAR:   ser_d   = par_d;
`endif
         STOP:  ser_d   = 1'b1;
         default: begin
            ser_d   = 1'b1;
            frame_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers; reset aborts any frame in flight.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
         ser_q   <= 1'b1;
         frame_q <= 1'b0;
`ifdef SERIAL_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         ser_q   <= ser_d;
         frame_q <= frame_d;
`ifdef SERIAL_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: doc/word_serializer.md
Name: word_serializer

Overview:
- Downstream consumer of the 16-bit OUTPUT_DATA word produced by the top-level datapath.
- Buffers incoming words in a small FIFO with a valid/ready handshake.
- Shifts each word out LSB-first on a single UART-style serial line: start bit, 16 data bits, optional parity, stop bit.
- Counts completed frames, so the bench can check throughput against words produced.

Parameters:
- DEPTH, 4: FIFO depth in words; power of two, at least 2.
- BAUD_DIV, 4: CLK cycles each serial bit is held; at least 1.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset; 0 resets, 1 runs.
- IN_DATA  input  16  word from the upstream stage (its OUTPUT_DATA).
- IN_VALID  input  1  IN_DATA is valid this cycle.
- IN_READY  output  1  FIFO can accept a word this cycle.
- SER_OUT  output  1  serial line; idles high.
- SER_FRAME  output  1  high for every cycle of a frame, start bit through stop bit.
- BUSY  output  1  FSM not in IDLE, or FIFO not empty.
- WORD_COUNT  output  16  number of frames fully transmitted; wraps.

Behaviour:
- Reset (RST=0, asynchronous):
  - FIFO flushed; FSM goes to IDLE.
  - SER_OUT=1; SER_FRAME=0; BUSY=0; WORD_COUNT=0.
  - IN_READY=1 once RST=1.
  - Reset in the middle of a frame aborts it immediately; the partial word is lost and not counted.
- Push:
  - A push happens on a rising edge where IN_VALID & IN_READY.
  - IN_READY = !full, combinational from the FIFO occupancy count.
  - When full, IN_VALID is ignored; IN_DATA must be held by upstream until accepted.
- Pop:
  - The FSM pops the head word in IDLE when the FIFO is non-empty, or at the end of STOP when non-empty.
- Push and pop in the same cycle:
  - Both take effect and occupancy is unchanged.
  - When full, the push is rejected, since IN_READY=0 at the start of that cycle.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: SER_OUT=1. If non-empty, pop into the 16-bit shift register and go to START.
  - START: SER_OUT=0 for BAUD_DIV cycles, then go to DATA.
  - DATA: SER_OUT=shift[0] for BAUD_DIV cycles per bit, then shift right. A 4-bit bit counter runs 0..15; after bit 15, go to PAR if enabled, otherwise STOP.
  - PAR: see Optional Feature.
  - STOP: SER_OUT=1 for BAUD_DIV cycles. Then WORD_COUNT increments and the FSM goes to START with a new pop if non-empty, otherwise to IDLE.
- Baud divider:
  - Counts 0..BAUD_DIV-1 and resets on every state entry.
  - Width is clog2(BAUD_DIV) bits, with a minimum of 1.
- Timing:
  - Latency: a word pushed into an empty FIFO at edge N gives SER_OUT=0 from edge N+1.
  - Frame length is 18*BAUD_DIV cycles, or 19*BAUD_DIV with parity.
  - Back-to-back frames have no idle cycle between the stop bit and the next start bit.
- Outputs:
  - SER_OUT and SER_FRAME are registered.
  - WORD_COUNT wraps from 16'hFFFF to 0.

Optional Feature:
- Macro SERIAL_PARITY_EN.
- Defined:
  - The PAR state is present and the frame is 19 bits.
  - The parity bit is the XOR of all 16 data bits (even parity), latched at pop.
- Undefined:
  - The PAR state and parity logic are absent and the frame is 18 bits.

Decomposition:
- Shared package ser_pkg holds:
  - the FSM state typedef (IDLE..STOP);
  - localparams WORD_W=16 and FRAME_BITS (18 or 19 via the macro).
- One sub-module, ser_fifo:
  - parameter DEPTH;
  - synchronous push/pop;
  - full/empty flags and a count output;
  - same CLK and active-low asynchronous RST.
- The FSM, shifter and counters stay in word_serializer.

Test Plan:
- Reset: hold RST=0 for 20ns, then release.
  - During reset: SER_OUT=1, SER_FRAME=0, BUSY=0, WORD_COUNT=0.
  - After release: IN_READY=1.
- Single word, BAUD_DIV=4: push 16'hA5C3.
  - Sampling SER_OUT every 4 cycles gives 0, then bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then 1.
  - WORD_COUNT=1 after 72 cycles.
- Back-to-back: push 16'h0001, 16'h8000, 16'hFFFF consecutively.
  - No idle high bit appears between frames.
  - WORD_COUNT=3 after 216 cycles.
- Full/backpressure: hold IN_VALID=1 for 6 words with DEPTH=4.
  - IN_READY drops after 5 accepts (one popped immediately).
  - All words arrive in order and none is duplicated.
- Reset mid-frame: assert RST=0 during DATA bit 7.
  - SER_OUT=1 immediately and the FIFO is empty.
  - WORD_COUNT=0.
  - The next pushed word transmits correctly.
- Parity (SERIAL_PARITY_EN): push 16'h0007.
  - Parity bit=1.
  - Frame is 19 bits (76 cycles at BAUD_DIV=4).
